// File: rtl/ov7670_captura_quadrantes_pkg.sv
// Shared definitions for the OV7670 quadrant capture block.
// Holds the FSM state encoding, the code reported for an illegal state, and
// the default frame geometry (640x480, 3x3 quadrant grid).
package ov7670_captura_quadrantes_pkg;

    localparam int LARGURA_PADRAO = 640;
    localparam int ALTURA_PADRAO  = 480;
    localparam int N_QUAD_PADRAO  = 3;

    typedef enum logic [3:0] {
        OCIOSO       = 4'd0,
        ESPERA_FRAME = 4'd1,
        ESPERA_LINHA = 4'd2,
        BYTE_ALTO    = 4'd3,
        BYTE_BAIXO   = 4'd4,
        FIM_LINHA    = 4'd5,
        PRONTO       = 4'd6
    } estado_t;

    localparam logic [3:0] ESTADO_INVALIDO = 4'hF;

endpackage

// File: rtl/ov7670_captura_quadrantes_if.sv
// Camera-side bus and pixel output bus of the quadrant capture block.
//   master : drives iniciar/continuo/VSYNC/HREF/transmite_byte/D, observes results
//   slave  : the capture block (receives camera signals, drives pixel outputs)
// Widths follow LARGURA/ALTURA/N_QUAD and must match the capture instance.
interface ov7670_captura_quadrantes_if
    import ov7670_captura_quadrantes_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int ALTURA  = ALTURA_PADRAO,
    parameter int N_QUAD  = N_QUAD_PADRAO
);
    localparam int LW = $clog2(ALTURA);
    localparam int CW = $clog2(LARGURA);
    localparam int QW = $clog2(N_QUAD);

    logic          iniciar;
    logic          continuo;
    logic          VSYNC;
    logic          HREF;
    logic          transmite_byte;
    logic [7:0]    D;

    logic          pixel_valido;
    logic [15:0]   pixel_dado;
    logic [LW-1:0] linha;
    logic [CW-1:0] coluna;
    logic [QW-1:0] quad_linha;
    logic [QW-1:0] quad_coluna;
    logic          frame_pronto;
    logic          erro_quadro;
    logic [3:0]    db_estado;

    modport master (
        output iniciar, continuo, VSYNC, HREF, transmite_byte, D,
        input  pixel_valido, pixel_dado, linha, coluna, quad_linha, quad_coluna,
               frame_pronto, erro_quadro, db_estado
    );

    modport slave (
        input  iniciar, continuo, VSYNC, HREF, transmite_byte, D,
        output pixel_valido, pixel_dado, linha, coluna, quad_linha, quad_coluna,
               frame_pronto, erro_quadro, db_estado
    );

endinterface

// File: rtl/ov7670_captura_quadrantes_contador_quadrante.sv
// contador_quadrante: maps a running pixel/line count onto a quadrant index.
// Every PERIODO advances the index steps by one and then sticks at N_MAX-1,
// so the last quadrant absorbs any remainder of the division.
// Ports: clock, reset (async, active low), limpa (sync clear),
//        avanca (count one element), indice (current quadrant).
module contador_quadrante #(
    parameter int PERIODO = 2,
    parameter int N_MAX   = 3,
    parameter int IW      = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          limpa,
    input  logic          avanca,
    output logic [IW-1:0] indice
);
    // a period of 1 still needs a 1-bit counter to stay legal
    localparam int PW = (PERIODO > 1) ? $clog2(PERIODO) : 1;
    localparam logic [PW-1:0] ULT_CNT = PW'(PERIODO - 1);
    localparam logic [IW-1:0] ULT_IDX = IW'(N_MAX - 1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            indice <= '0;
        end else if (limpa) begin
            cnt    <= '0;
            indice <= '0;
        end else if (avanca) begin
            if (cnt == ULT_CNT) begin
                cnt <= '0;
                if (indice != ULT_IDX)
                    indice <= indice + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ov7670_captura_quadrantes.sv
// ov7670_captura_quadrantes: captures RGB565 pixels from an OV7670 byte
// stream (VSYNC/HREF already synchronised) and tags each pixel with its row,
// column and position in an N_QUAD x N_QUAD quadrant grid.
// Ports: clock, reset (async, active low), bus (slave modport: camera inputs,
//        pixel/coordinate/quadrant outputs, frame_pronto, erro_quadro, db_estado).
// Optional build macro OV7670_SUBAMOSTRAGEM_EN: only pixels at even row and
// even column raise pixel_valido; counters and quadrants keep running.
module ov7670_captura_quadrantes
    import ov7670_captura_quadrantes_pkg::*;
#(
    parameter int LARGURA = LARGURA_PADRAO,
    parameter int ALTURA  = ALTURA_PADRAO,
    parameter int N_QUAD  = N_QUAD_PADRAO
) (
    input  logic clock,
    input  logic reset,
    ov7670_captura_quadrantes_if.slave bus
);
    localparam int LW = $clog2(ALTURA);
    localparam int CW = $clog2(LARGURA);
    localparam int QW = $clog2(N_QUAD);
    localparam int Q  = LARGURA / N_QUAD;
    localparam int R  = ALTURA / N_QUAD;

    // row counter carries one spare bit so it can legally reach ALTURA
    localparam logic [LW:0]   ULT_LINHA = (LW + 1)'(ALTURA - 1);
    localparam logic [LW:0]   ALTURA_L  = (LW + 1)'(ALTURA);
    localparam logic [CW-1:0] ULT_COL   = CW'(LARGURA - 1);

    estado_t estado, prox_estado;

    logic          vsync_ant;
    logic [7:0]    byte_alto;
    logic [15:0]   pixel_dado_q;
    logic          pix_int;
    logic          erro_q;
    logic [LW:0]   linha_q;
    logic [CW-1:0] coluna_q;
    logic          cheia;
    logic [QW-1:0] quad_lin_q, quad_col_q;

    logic queda_vsync, bloqueio, strobe_ok, erro_cond;
    logic limpa, carrega_alto, carrega_baixo, fim_linha, aborta, frame_pronto_c;
    logic [3:0] db_estado_c;

    assign queda_vsync = vsync_ant & ~bus.VSYNC;
    // the line is full from the cycle its last pixel is reported, not one later
    assign bloqueio    = cheia | (pix_int & (coluna_q == ULT_COL));
    assign strobe_ok   = bus.transmite_byte & bus.HREF & ~bloqueio;
    assign erro_cond   = bus.VSYNC & (linha_q < ALTURA_L);

    // state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= OCIOSO;
        else        estado <= prox_estado;
    end

    // next state
    always_comb begin
        prox_estado = estado;
        case (estado)
            OCIOSO:       if (bus.iniciar) prox_estado = ESPERA_FRAME;
            ESPERA_FRAME: if (queda_vsync) prox_estado = ESPERA_LINHA;
            ESPERA_LINHA: begin
                if (erro_cond)     prox_estado = ESPERA_FRAME;
                else if (bus.HREF) prox_estado = BYTE_ALTO;
            end
            // HREF low wins over a simultaneous strobe: half pixels are dropped
            BYTE_ALTO: begin
                if (!bus.HREF)     prox_estado = FIM_LINHA;
                else if (strobe_ok) prox_estado = BYTE_BAIXO;
            end
            BYTE_BAIXO: begin
                if (!bus.HREF)     prox_estado = FIM_LINHA;
                else if (strobe_ok) prox_estado = BYTE_ALTO;
            end
            FIM_LINHA:    prox_estado = (linha_q == ULT_LINHA) ? PRONTO : ESPERA_LINHA;
            PRONTO:       prox_estado = bus.continuo ? ESPERA_FRAME : OCIOSO;
            default:      prox_estado = OCIOSO;
        endcase
    end

    // outputs and datapath controls
    always_comb begin
        db_estado_c    = ESTADO_INVALIDO;
        frame_pronto_c = 1'b0;
        limpa          = 1'b0;
        carrega_alto   = 1'b0;
        carrega_baixo  = 1'b0;
        fim_linha      = 1'b0;
        aborta         = 1'b0;
        case (estado)
            OCIOSO:       db_estado_c = estado;
            ESPERA_FRAME: begin db_estado_c = estado; limpa = queda_vsync; end
            ESPERA_LINHA: begin db_estado_c = estado; aborta = erro_cond; end
            BYTE_ALTO:    begin db_estado_c = estado; carrega_alto = strobe_ok; end
            BYTE_BAIXO:   begin db_estado_c = estado; carrega_baixo = strobe_ok; end
            FIM_LINHA:    begin db_estado_c = estado; fim_linha = 1'b1; end
            PRONTO:       begin db_estado_c = estado; frame_pronto_c = 1'b1; end
            default:      ;
        endcase
    end

    // Coordinates are advanced on the cycle the pixel is reported, so the
    // live counters already line up with pixel_valido.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vsync_ant    <= 1'b0;
            byte_alto    <= '0;
            pixel_dado_q <= '0;
            pix_int      <= 1'b0;
            erro_q       <= 1'b0;
            linha_q      <= '0;
            coluna_q     <= '0;
            cheia        <= 1'b0;
        end else begin
            vsync_ant <= bus.VSYNC;
            pix_int   <= carrega_baixo;
            erro_q    <= aborta;
            if (carrega_alto)  byte_alto    <= bus.D;
            if (carrega_baixo) pixel_dado_q <= {byte_alto, bus.D};
            if (limpa) begin
                linha_q  <= '0;
                coluna_q <= '0;
                cheia    <= 1'b0;
            end else if (fim_linha) begin
                linha_q  <= linha_q + 1'b1;
                coluna_q <= '0;
                cheia    <= 1'b0;
            end else if (pix_int) begin
                if (coluna_q == ULT_COL) cheia    <= 1'b1;
                else                     coluna_q <= coluna_q + 1'b1;
            end
        end
    end

    contador_quadrante #(.PERIODO(Q), .N_MAX(N_QUAD), .IW(QW)) u_quad_coluna (
        .clock  (clock),
        .reset  (reset),
        .limpa  (limpa | fim_linha),
        .avanca (pix_int),
        .indice (quad_col_q)
    );

    contador_quadrante #(.PERIODO(R), .N_MAX(N_QUAD), .IW(QW)) u_quad_linha (
        .clock  (clock),
        .reset  (reset),
        .limpa  (limpa),
        .avanca (fim_linha),
        .indice (quad_lin_q)
    );

`ifdef OV7670_SUBAMOSTRAGEM_EN
    assign bus.pixel_valido = pix_int & ~linha_q[0] & ~coluna_q[0];
`else
    assign bus.pixel_valido = pix_int;
`endif
    assign bus.pixel_dado   = pixel_dado_q;
    assign bus.linha        = linha_q[LW-1:0];
    assign bus.coluna       = coluna_q;
    assign bus.quad_linha   = quad_lin_q;
    assign bus.quad_coluna  = quad_col_q;
    assign bus.frame_pronto = frame_pronto_c;
    assign bus.erro_quadro  = erro_q;
    assign bus.db_estado    = db_estado_c;

endmodule

// File: tb/tb_ov7670_captura_quadrantes.sv
// Self-checking bench: 6x4 frame, 3x3 quadrants, plus a 7-wide instance fed
// by the same stimulus to observe quadrant saturation at the last column.
module tb_ov7670_captura_quadrantes;
    import ov7670_captura_quadrantes_pkg::*;

    localparam int LARG = 6, ALT = 4, NQ = 3, LARG7 = 7;
    localparam int Q = LARG / NQ, R = ALT / NQ;
`ifdef OV7670_SUBAMOSTRAGEM_EN
    localparam int NPIX_QUADRO = 6;
    localparam int NCOL6_QUADRO = 2;
`else
    localparam int NPIX_QUADRO = 24;
    localparam int NCOL6_QUADRO = 4;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic       iniciar = 0, continuo = 0, vsync = 0, href = 0, strobe = 0;
    logic [7:0] d = '0;

    ov7670_captura_quadrantes_if #(.LARGURA(LARG),  .ALTURA(ALT), .N_QUAD(NQ)) bus ();
    ov7670_captura_quadrantes_if #(.LARGURA(LARG7), .ALTURA(ALT), .N_QUAD(NQ)) bus7 ();

    assign bus.iniciar  = iniciar;  assign bus7.iniciar  = iniciar;
    assign bus.continuo = continuo; assign bus7.continuo = continuo;
    assign bus.VSYNC    = vsync;    assign bus7.VSYNC    = vsync;
    assign bus.HREF     = href;     assign bus7.HREF     = href;
    assign bus.transmite_byte = strobe; assign bus7.transmite_byte = strobe;
    assign bus.D        = d;        assign bus7.D        = d;

    ov7670_captura_quadrantes #(.LARGURA(LARG), .ALTURA(ALT), .N_QUAD(NQ)) u_dut (
        .clock (clock), .reset (reset), .bus (bus)
    );
    ov7670_captura_quadrantes #(.LARGURA(LARG7), .ALTURA(ALT), .N_QUAD(NQ)) u_dut7 (
        .clock (clock), .reset (reset), .bus (bus7)
    );

    typedef struct packed {
        logic [15:0] dado;
        logic [1:0]  lin;
        logic [2:0]  col;
        logic [1:0]  ql;
        logic [1:0]  qc;
    } pix_t;

    pix_t fila[$];
    int n_testes = 0, n_falhas = 0;
    int n_pronto = 0, n_erro = 0, n_pix = 0, n_col6 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_testes++;
        if (obs !== esp) begin
            n_falhas++;
            $display("FAIL %s: obtido %0h esperado %0h", tag, obs, esp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    function automatic int quad(input int v, input int per);
        int q = v / per;
        return (q > NQ - 1) ? NQ - 1 : q;
    endfunction

    task automatic espera_pix(input int lin, input int col, input logic [15:0] dado);
        pix_t e;
`ifdef OV7670_SUBAMOSTRAGEM_EN
        if ((lin % 2) != 0 || (col % 2) != 0) return;
`endif
        e.dado = dado;
        e.lin  = 2'(lin);
        e.col  = 3'(col);
        e.ql   = 2'(quad(lin, R));
        e.qc   = 2'(quad(col, Q));
        fila.push_back(e);
    endtask

    // one line of nbytes; byte value = base + inc*column; optional extra
    // strobe on the same cycle HREF falls (must be ignored)
    task automatic linha_tx(input int lin, input int nbytes, input bit strobe_queda,
                            input logic [7:0] ba, input logic [7:0] bb,
                            input logic [7:0] inc, input bit esperado);
        logic [7:0] alto;
        alto = '0;
        href = 1'b1;
        tick(1);
        for (int i = 0; i < nbytes; i++) begin
            int col = i / 2;
            d = ((i % 2) == 0) ? ba + 8'(inc * col) : bb + 8'(inc * col);
            if ((i % 2) == 0) alto = d;
            strobe = 1'b1;
            tick(1);
            if ((i % 2) == 1 && col < LARG && esperado) espera_pix(lin, col, {alto, d});
            strobe = 1'b0;
            tick(1);
        end
        if (strobe_queda) begin
            d = 8'hEE; strobe = 1'b1; href = 1'b0;
            tick(1);
            strobe = 1'b0;
        end else begin
            href = 1'b0;
        end
        tick(3);
    endtask

    task automatic quadro_sync();
        vsync = 1'b1; tick(2);
        vsync = 1'b0; tick(2);
    endtask

    always @(negedge clock) begin
        pix_t e;
        if (bus.frame_pronto) n_pronto++;
        if (bus.erro_quadro)  n_erro++;
        if (bus.pixel_valido) begin
            if (fila.size() == 0) chk("pix_inesperado", 1, 0);
            else begin
                e = fila.pop_front();
                n_pix++;
                chk("pix_dado", bus.pixel_dado,  e.dado);
                chk("pix_lin",  bus.linha,       e.lin);
                chk("pix_col",  bus.coluna,      e.col);
                chk("pix_ql",   bus.quad_linha,  e.ql);
                chk("pix_qc",   bus.quad_coluna, e.qc);
            end
        end
        if (bus7.pixel_valido && bus7.coluna == 3'd6) begin
            n_col6++;
            chk("sat7_qc", bus7.quad_coluna, 2);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: tempo esgotado");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, e0, x0, c0;
        #2 reset = 1'b0;
        tick(2);
        chk("rst_estado", bus.db_estado, 0);
        chk("rst_valido", bus.pixel_valido, 0);
        chk("rst_dado",   bus.pixel_dado, 0);
        chk("rst_pronto", bus.frame_pronto, 0);
        reset = 1'b1;
        tick(2);

        // full frame, single shot, constant bytes
        continuo = 1'b0;
        iniciar = 1'b1; tick(1); iniciar = 1'b0; tick(1);
        chk("f1_espera", bus.db_estado, 1);
        quadro_sync();
        chk("f1_linha", bus.db_estado, 2);
        p0 = n_pronto; e0 = n_erro; x0 = n_pix;
        for (int l = 0; l < ALT; l++) linha_tx(l, 12, 1'b0, 8'h12, 8'h34, 8'h00, 1'b1);
        tick(3);
        chk("f1_pronto", n_pronto - p0, 1);
        chk("f1_erro",   n_erro - e0, 0);
        chk("f1_npix",   n_pix - x0, NPIX_QUADRO);
        chk("f1_fila",   fila.size(), 0);
        chk("f1_ocioso", bus.db_estado, 0);

        // short line, then a full line, then early VSYNC aborts
        continuo = 1'b1;
        iniciar = 1'b1; tick(1); iniciar = 1'b0; tick(1);
        quadro_sync();
        p0 = n_pronto; e0 = n_erro;
        linha_tx(0, 5,  1'b0, 8'hA0, 8'h50, 8'h01, 1'b1);
        linha_tx(1, 12, 1'b0, 8'hA0, 8'h50, 8'h01, 1'b1);
        vsync = 1'b1;
        tick(4);
        chk("f2_erro",   n_erro - e0, 1);
        chk("f2_pronto", n_pronto - p0, 0);
        chk("f2_estado", bus.db_estado, 1);
        chk("f2_fila",   fila.size(), 0);

        // overlong lines and a strobe on HREF falling; continuous re-arm
        vsync = 1'b0; tick(2);
        p0 = n_pronto; x0 = n_pix; c0 = n_col6;
        for (int l = 0; l < ALT; l++) linha_tx(l, 14, 1'b1, 8'hC0, 8'h30, 8'h01, 1'b1);
        tick(3);
        chk("f3_pronto", n_pronto - p0, 1);
        chk("f3_npix",   n_pix - x0, NPIX_QUADRO);
        chk("f3_rearme", bus.db_estado, 1);
        chk("f3_fila",   fila.size(), 0);
        chk("f3_sat7_n", n_col6 - c0, NCOL6_QUADRO);

        // reset mid-line
        quadro_sync();
        href = 1'b1; tick(1);
        d = 8'h11; strobe = 1'b1; tick(1); strobe = 1'b0; tick(1);
        d = 8'h22; strobe = 1'b1; tick(1); espera_pix(0, 0, 16'h1122); strobe = 1'b0; tick(1);
        d = 8'h33; strobe = 1'b1; tick(1); strobe = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("rm_estado", bus.db_estado, 0);
        chk("rm_dado",   bus.pixel_dado, 0);
        chk("rm_col",    bus.coluna, 0);
        chk("rm_lin",    bus.linha, 0);
        chk("rm_qc",     bus.quad_coluna, 0);
        chk("rm_valido", bus.pixel_valido, 0);
        chk("rm_erro",   bus.erro_quadro, 0);
        href = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(2);
        x0 = n_pix;
        quadro_sync();
        linha_tx(0, 12, 1'b0, 8'h77, 8'h88, 8'h00, 1'b0);
        chk("rm_semcap", n_pix - x0, 0);
        chk("rm_ocioso", bus.db_estado, 0);
        chk("rm_fila",   fila.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_testes, n_falhas);
        $finish;
    end

endmodule
